// File: rtl/mac32_dot_sequencer.sv
// mac32_dot_sequencer
//   Feeds a combinational FP32 MAC (A + B*C) with a stream of (B,C) pairs.
//   The running accumulator drives A, and each MAC result is captured back
//   into the accumulator. The final dot product init + sum(B[k]*C[k]) is
//   returned over a valid/ready handshake.
// Ports
//   clk_i, rst_i             clock (rising edge), async active-high reset
//   start_i/len_i/init_i     job start, pair count, initial accumulator
//   op_valid_i/op_ready_o    operand pair handshake, op_b_i/op_c_i operands
//   mac_a_o/b_o/c_o          MAC operands (accumulator, staged B, staged C)
//   mac_result_i             MAC result, captured on retire
//   res_valid_o/res_ready_i  result handshake, res_data_o result
//   busy_o                   job in flight (ACCUM or DONE)
//   ovf_flag_o               sticky: a retired result had an all-ones exponent
module mac32_dot_sequencer #(
  parameter int PARM_XLEN  = 32,
  parameter int PARM_EXP   = 8,
  parameter int PARM_MANT  = 23,
  parameter int PARM_LEN_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [PARM_LEN_W-1:0] len_i,
  input  logic [PARM_XLEN-1:0]  init_i,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic [PARM_XLEN-1:0]  op_b_i,
  input  logic [PARM_XLEN-1:0]  op_c_i,
  output logic [PARM_XLEN-1:0]  mac_a_o,
  output logic [PARM_XLEN-1:0]  mac_b_o,
  output logic [PARM_XLEN-1:0]  mac_c_o,
  input  logic [PARM_XLEN-1:0]  mac_result_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [PARM_XLEN-1:0]  res_data_o,
  output logic                  busy_o,
  output logic                  ovf_flag_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                r_state;
  logic [PARM_XLEN-1:0]  r_acc;
  logic [PARM_XLEN-1:0]  r_b;
  logic [PARM_XLEN-1:0]  r_c;
  logic [PARM_LEN_W-1:0] r_issue_cnt;
  logic [PARM_LEN_W-1:0] r_retire_cnt;
  logic                  r_stage_vld;
  logic                  r_ovf;

  logic w_ready;
  logic w_accept;
  logic w_res_inf;

  // Ready depends only on state and remaining issue count, never on valid.
  assign w_ready   = (r_state == S_ACCUM) && (r_issue_cnt != '0);
  assign w_accept  = w_ready && op_valid_i;
  // Exponent field sits directly above the mantissa.
  assign w_res_inf = &mac_result_i[PARM_MANT +: PARM_EXP];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_issue_cnt  <= '0;
      r_retire_cnt <= '0;
      r_stage_vld  <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_stage_vld <= 1'b0;
          if (start_i) begin
            r_acc        <= init_i;
            r_issue_cnt  <= len_i;
            r_retire_cnt <= len_i;
            r_ovf        <= 1'b0;
            r_state      <= (len_i != '0) ? S_ACCUM : S_DONE;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_b         <= op_b_i;
            r_c         <= op_c_i;
            r_issue_cnt <= r_issue_cnt - 1'b1;
          end
          // A retire and a new accept may share an edge; the new pair then
          // sees the freshly updated accumulator on the next cycle.
          r_stage_vld <= w_accept;
          if (r_stage_vld) begin
            r_acc        <= mac_result_i;
            r_retire_cnt <= r_retire_cnt - 1'b1;
            if (w_res_inf) r_ovf <= 1'b1;
            if (r_retire_cnt == {{(PARM_LEN_W-1){1'b0}}, 1'b1}) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_stage_vld <= 1'b0;
          if (res_ready_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign op_ready_o  = w_ready;
  assign mac_a_o     = r_acc;
  assign mac_b_o     = r_b;
  assign mac_c_o     = r_c;
  assign res_valid_o = (r_state == S_DONE);
  assign res_data_o  = r_acc;
  assign busy_o      = (r_state != S_IDLE);
  assign ovf_flag_o  = r_ovf;

endmodule

// File: tb/tb_mac32_dot_sequencer.sv
module tb_mac32_dot_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  len_i = '0;
  logic [31:0] init_i = '0;
  logic        op_valid_i = 1'b0;
  logic        op_ready_o;
  logic [31:0] op_b_i = '0;
  logic [31:0] op_c_i = '0;
  logic [31:0] mac_a_o, mac_b_o, mac_c_o;
  logic [31:0] mac_result_i;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic [31:0] res_data_o;
  logic        busy_o;
  logic        ovf_flag_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  mac32_dot_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .init_i(init_i),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_b_i(op_b_i), .op_c_i(op_c_i),
    .mac_a_o(mac_a_o), .mac_b_o(mac_b_o), .mac_c_o(mac_c_o), .mac_result_i(mac_result_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .busy_o(busy_o), .ovf_flag_o(ovf_flag_o)
  );

  // Behavioural stand-in for the external combinational FP32 MAC, computed
  // in double precision (exact for the directed vectors used here).
  function automatic logic [63:0] f2d(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'h00) return {f[31], 63'b0};
    if (f[30:23] == 8'hFF) return {f[31], 11'h7FF, f[22:0], 29'b0};
    e = 11'(f[30:23]) + 11'd896;
    return {f[31], e, f[22:0], 29'b0};
  endfunction

  function automatic logic [31:0] d2f(input logic [63:0] d);
    int e;
    if (d[62:52] == 11'h000) return {d[63], 31'b0};
    if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, d[51:29]};
    e = int'(d[62:52]) - 896;
    if (e >= 255) return {d[63], 8'hFF, 23'b0};
    if (e <= 0) return {d[63], 31'b0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  always_comb begin
    mac_result_i = d2f($realtobits($bitstoreal(f2d(mac_a_o)) +
                   $bitstoreal(f2d(mac_b_o)) * $bitstoreal(f2d(mac_c_o))));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_ready"}, {31'b0, op_ready_o}, 32'd0);
    chk({tag, "_valid"}, {31'b0, res_valid_o}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
    chk({tag, "_ovf"}, {31'b0, ovf_flag_o}, 32'd0);
    chk({tag, "_maca"}, mac_a_o, 32'd0);
    chk({tag, "_macb"}, mac_b_o, 32'd0);
    chk({tag, "_macc"}, mac_c_o, 32'd0);
    chk({tag, "_data"}, res_data_o, 32'd0);
  endtask

  // Called on a negedge; returns on the negedge after the start edge.
  task automatic do_start(input logic [31:0] init, input logic [7:0] len);
    start_i = 1'b1; init_i = init; len_i = len;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic finish_handshake(input string tag);
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
    chk({tag, "_idle_valid"}, {31'b0, res_valid_o}, 32'd0);
    chk({tag, "_idle_busy"}, {31'b0, busy_o}, 32'd0);
  endtask

  task automatic run_t1(input string tag);
    do_start(32'h3FC00000, 8'd1);
    chk({tag, "_ready"}, {31'b0, op_ready_o}, 32'd1);
    chk({tag, "_busy"}, {31'b0, busy_o}, 32'd1);
    op_valid_i = 1'b1; op_b_i = 32'h40000000; op_c_i = 32'h40400000;
    @(negedge clk_i);          // pair accepted at the edge just passed
    op_valid_i = 1'b0;
    chk({tag, "_ready_after"}, {31'b0, op_ready_o}, 32'd0);
    chk({tag, "_macb"}, mac_b_o, 32'h40000000);
    chk({tag, "_valid_early"}, {31'b0, res_valid_o}, 32'd0);
    @(negedge clk_i);          // two cycles after the accept cycle
    chk({tag, "_valid"}, {31'b0, res_valid_o}, 32'd1);
    chk({tag, "_data"}, res_data_o, 32'h40F00000);
    finish_handshake(tag);
  endtask

  // T2 body: four pairs with valid held high; ends in DONE.
  task automatic run_t2(input string tag);
    logic [31:0] vals [4];
    int idx, n_rdy;
    logic rdy;
    vals[0] = 32'h3F800000; vals[1] = 32'h40000000;
    vals[2] = 32'h40400000; vals[3] = 32'h40800000;
    idx = 0; n_rdy = 0;
    do_start(32'h00000000, 8'd4);
    op_valid_i = 1'b1; op_c_i = 32'h3F800000;
    for (int cyc = 0; cyc < 20 && !res_valid_o; cyc++) begin
      if (idx < 4) op_b_i = vals[idx];
      rdy = op_ready_o;
      @(posedge clk_i);
      if (rdy) begin idx++; n_rdy++; end
      @(negedge clk_i);
    end
    op_valid_i = 1'b0;
    chk({tag, "_ready_cycles"}, 32'(n_rdy), 32'd4);
    chk({tag, "_valid"}, {31'b0, res_valid_o}, 32'd1);
    chk({tag, "_data"}, res_data_o, 32'h41200000);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk_i);
    chk_zero_outs("reset");
    rst_i = 1'b0;
    @(negedge clk_i);

    // T1
    run_t1("t1");

    // T2
    run_t2("t2");
    finish_handshake("t2");

    // T3: zero-length job
    do_start(32'h40490FDB, 8'd0);
    chk("t3_valid", {31'b0, res_valid_o}, 32'd1);
    chk("t3_data", res_data_o, 32'h40490FDB);
    chk("t3_ready", {31'b0, op_ready_o}, 32'd0);
    finish_handshake("t3");

    // T4: back-pressure with a stray start pulse
    run_t2("t4");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin start_i = 1'b1; init_i = 32'h12345678; len_i = 8'd0; end
      else start_i = 1'b0;
      @(negedge clk_i);
      chk("t4_hold_valid", {31'b0, res_valid_o}, 32'd1);
      chk("t4_hold_data", res_data_o, 32'h41200000);
    end
    start_i = 1'b0;
    finish_handshake("t4");
    @(negedge clk_i);
    chk("t4_no_restart", {31'b0, busy_o}, 32'd0);

    // T5: overflow to infinity
    do_start(32'h00000000, 8'd1);
    op_valid_i = 1'b1; op_b_i = 32'h7F7FFFFF; op_c_i = 32'h40000000;
    @(negedge clk_i);
    op_valid_i = 1'b0;
    chk("t5_ovf_before", {31'b0, ovf_flag_o}, 32'd0);
    @(negedge clk_i);
    chk("t5_valid", {31'b0, res_valid_o}, 32'd1);
    chk("t5_data", res_data_o, 32'h7F800000);
    chk("t5_ovf", {31'b0, ovf_flag_o}, 32'd1);
    finish_handshake("t5");
    chk("t5_ovf_sticky", {31'b0, ovf_flag_o}, 32'd1);
    do_start(32'h3F800000, 8'd0);
    chk("t5_ovf_cleared", {31'b0, ovf_flag_o}, 32'd0);
    finish_handshake("t5b");

    // T6: reset mid-job, then T1 again
    do_start(32'h3F800000, 8'd4);
    op_valid_i = 1'b1; op_b_i = 32'h40000000; op_c_i = 32'h40000000;
    repeat (2) @(negedge clk_i);
    chk("t6_busy", {31'b0, busy_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk_zero_outs("t6_rst");
    op_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    run_t1("t6_t1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
